xdma_write_burst_arbiter: RTL
=============================

// Module: xdma_write_burst_arbiter
// PURPOSE
// Shares one reqrsp write port between NumReq AXI-write-to-reqrsp converters.
// - Round-robin arbitration at burst granularity: a granted requester holds the port until its last beat.
// - Records the source of every started burst in an in-order FIFO.
// - Routes each downstream write-completion pulse back to the requester that owns it.
// Sits between the per-port AXI write converters and the single memory/cfg write port.
// PARAMETERS
// NumReq       4    number of requesters (>=2)
// AddrWidth    48   request address width
// DataWidth    512  request data width; strobe width is DataWidth/8
// AckFifoDepth 4    max bursts started but not yet acknowledged (power of 2)
// PORTS
// clk_i        in   1                 clock, all logic on rising edge
// rst_i        in   1                 synchronous reset, active-high
// req_valid_i  in   NumReq            per-requester beat valid
// req_ready_o  out  NumReq            per-requester beat ready
// req_addr_i   in   NumReq*AddrWidth  per-requester beat address, requester i at [i*AddrWidth +: AddrWidth]
// req_data_i   in   NumReq*DataWidth  per-requester write data
// req_strb_i   in   NumReq*DataWidth/8 per-requester byte strobes
// req_last_i   in   NumReq            beat is last of its burst
// out_valid_o  out  1                 muxed beat valid
// out_ready_i  in   1                 downstream accepts beat
// out_addr_o   out  AddrWidth         muxed address
// out_data_o   out  DataWidth         muxed data
// out_strb_o   out  DataWidth/8       muxed strobes
// out_last_o   out  1                 muxed last flag
// out_src_o    out  $clog2(NumReq)    index of the requester currently driving the output
// out_ack_i    in   1                 one-cycle pulse: oldest outstanding burst completed
// ack_o        out  NumReq            one-hot one-cycle completion pulse to the owning requester
// ack_err_o    out  1                 sticky: out_ack_i arrived with no outstanding burst
// busy_o       out  1                 high in LOCKED, when any req_valid_i is high, or when the FIFO is non-empty
// BEHAVIOUR
// - Reset (rst_i=1 at a clock edge):
//   - state=IDLE, rr_ptr=0, FIFO emptied, ack_err_o=0.
//   - All outputs are combinational from this state, so out_valid_o, req_ready_o, ack_o and busy_o read 0
//     for the first cycle after reset (req_valid_i held low).
//   - A reset mid-burst drops the burst; the requester must restart.
// - Handshakes:
//   - fire = out_valid_o & out_ready_i.
//   - req_ready_o[g] = out_ready_i for the selected g only, 0 for all other requesters.
//   - Output path is combinational, 0-cycle latency: the selected requester's addr/data/strb/last are forwarded.
// - State IDLE:
//   - Candidate g = first i with req_valid_i[i], searching rr_ptr, rr_ptr+1, ... mod NumReq.
//   - No candidate if no valid requester, or if the FIFO is full.
//   - With a candidate: out_valid_o=1, out_src_o=g; grant_q<=g at the clock edge.
//   - fire & last: push g into the FIFO; rr_ptr<=(g+1) mod NumReq; stay IDLE.
//   - fire & !last: push g; go to LOCKED.
//   - no fire: go to LOCKED, with no push yet. This keeps valid/data stable per handshake rules and lets no
//     other requester overtake.
// - State LOCKED:
//   - Only grant_q is forwarded; out_valid_o=req_valid_i[grant_q].
//   - The first fire of a burst entered without a push pushes grant_q (tracked by a started_q flag).
//   - FIFO-full never blocks LOCKED: its push slot was checked at grant time.
//   - fire & last: go to IDLE; rr_ptr<=(grant_q+1) mod NumReq.
//   - A requester dropping valid mid-burst stalls the port; no re-arbitration.
// - Ack path:
//   - out_ack_i & FIFO non-empty: pop the head h; ack_o=(1<<h) in that same cycle.
//   - out_ack_i & FIFO empty: no ack_o; ack_err_o<=1. This holds even if a push happens in the same cycle,
//     because an ack always refers to an earlier burst.
//   - Push and pop in the same cycle: occupancy unchanged.
//   - Occupancy counter is $clog2(AckFifoDepth)+1 bits; pointers wrap modulo AckFifoDepth.
// - Single-beat bursts (last on the first beat) are granted and released in one cycle; back-to-back
//   rotation needs no idle cycle.
// TESTING
// - Reset, then req 0 and req 2 send 1-beat bursts simultaneously, out_ready_i=1: order 0 then 2 on
//   consecutive cycles, out_src_o=0,2, rr_ptr ends 3.
// - Req 1 sends 4-beat burst; req 3 asserts valid at beat 2: req 3 stays req_ready_o=0 until the cycle
//   after req 1 last fires; out_src_o is never 3 mid-burst.
// - out_ready_i low for 3 cycles on the first beat of req 2 while req 0 raises valid: output stays locked
//   on req 2 with data stable; FIFO push only on the actual fire.
// - AckFifoDepth=4: start 4 bursts without acks, then a 5th requester valid -> out_valid_o=0. One
//   out_ack_i -> ack_o one-hot for the first burst's source, and the 5th burst is granted next cycle.
// - Acks return in order for sources 3,0,1: ack_o = 4'b1000, 4'b0001, 4'b0010. An extra out_ack_i with
//   the FIFO empty -> ack_o=0, ack_err_o=1 and held.
// - rst_i pulsed mid-burst (beat 2 of 4): next cycle out_valid_o=0 with req_valid_i held low, FIFO empty,
//   ack_err_o=0; the next grant starts from requester 0.

Source files
------------

// File: rtl/xdma_write_burst_arbiter.sv
// Burst-granular round-robin arbiter that shares one reqrsp write port
// between NumReq AXI-write converters. The source of every started burst is
// kept in an in-order FIFO, so that each downstream completion pulse can be
// returned to the requester that owns it.
module xdma_write_burst_arbiter #(
    parameter int NumReq       = 4,
    parameter int AddrWidth    = 48,
    parameter int DataWidth    = 512,
    parameter int AckFifoDepth = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    input  logic [NumReq*DataWidth/8-1:0] req_strb_i,
    input  logic [NumReq-1:0]             req_last_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [AddrWidth-1:0]          out_addr_o,
    output logic [DataWidth-1:0]          out_data_o,
    output logic [DataWidth/8-1:0]        out_strb_o,
    output logic                          out_last_o,
    output logic [$clog2(NumReq)-1:0]     out_src_o,
    input  logic                          out_ack_i,
    output logic [NumReq-1:0]             ack_o,
    output logic                          ack_err_o,
    output logic                          busy_o
);

    localparam int SrcW  = $clog2(NumReq);
    localparam int StrbW = DataWidth / 8;
    localparam int PtrW  = $clog2(AckFifoDepth);
    localparam int CntW  = $clog2(AckFifoDepth) + 1;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // Requester index (base + offs) mod NumReq, valid for any NumReq.
    function automatic logic [SrcW-1:0] rr_add(input logic [SrcW-1:0] base, input int offs);
        int sum;
        sum = (int'(base) + offs) % NumReq;
        return SrcW'(sum);
    endfunction

    state_t            r_state;
    logic [SrcW-1:0]   r_rr_ptr;
    logic [SrcW-1:0]   r_grant;
    logic              r_started;
    logic              r_ack_err;
    logic [SrcW-1:0]   r_fifo [AckFifoDepth];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [CntW-1:0]   r_count;

    state_t            w_state_nxt;
    logic [SrcW-1:0]   w_rr_nxt;
    logic [SrcW-1:0]   w_grant_nxt;
    logic              w_started_nxt;
    logic              w_cand_found;
    logic [SrcW-1:0]   w_cand;
    logic [SrcW-1:0]   w_sel;
    logic              w_active;
    logic              w_out_valid;
    logic              w_push;
    logic [SrcW-1:0]   w_push_src;
    logic              w_pop;
    logic              w_fifo_full;
    logic              w_fifo_empty;

    assign w_fifo_full  = (r_count == CntW'(AckFifoDepth));
    assign w_fifo_empty = (r_count == '0);
    assign w_pop        = out_ack_i & ~w_fifo_empty;

    // Round-robin search: scan offsets from the highest down so that the
    // requester closest to r_rr_ptr is the last (and winning) assignment.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand       = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_valid_i[rr_add(r_rr_ptr, k)]) begin
                w_cand_found = 1'b1;
                w_cand       = rr_add(r_rr_ptr, k);
            end
        end
    end

    // Next-state logic: grant a new burst in IDLE, hold the owner in LOCKED.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_nxt   = r_state;
        w_rr_nxt      = r_rr_ptr;
        w_grant_nxt   = r_grant;
        w_started_nxt = r_started;
        w_sel         = r_grant;
        w_active      = 1'b0;
        w_out_valid   = 1'b0;
        w_push        = 1'b0;
        w_push_src    = r_grant;
        case (r_state)
            ST_IDLE: begin
                // A full FIFO blocks new grants so every burst has a push slot.
                if (w_cand_found && !w_fifo_full) begin
                    w_sel       = w_cand;
                    w_active    = 1'b1;
                    w_out_valid = 1'b1;
                    w_grant_nxt = w_cand;
                    w_push_src  = w_cand;
                    if (out_ready_i) begin
                        w_push = 1'b1;
                        if (req_last_i[w_cand]) begin
                            w_rr_nxt = rr_add(w_cand, 1);
                        end else begin
                            w_state_nxt   = ST_LOCKED;
                            w_started_nxt = 1'b1;
                        end
                    end else begin
                        // Lock without pushing so no other requester can overtake
                        // a beat that is already presented downstream.
                        w_state_nxt   = ST_LOCKED;
                        w_started_nxt = 1'b0;
                    end
                end
            end
            ST_LOCKED: begin
                w_sel       = r_grant;
                w_active    = 1'b1;
                w_out_valid = req_valid_i[r_grant];
                if (w_out_valid && out_ready_i) begin
                    w_push        = ~r_started;
                    w_started_nxt = 1'b1;
                    if (req_last_i[r_grant]) begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = rr_add(r_grant, 1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Arbiter state, FIFO pointers/occupancy and sticky error flag.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_started <= 1'b0;
            r_ack_err <= 1'b0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rr_ptr  <= w_rr_nxt;
            r_grant   <= w_grant_nxt;
            r_started <= w_started_nxt;
            if (out_ack_i && w_fifo_empty) begin
                r_ack_err <= 1'b1;
            end
            if (w_push) begin
                r_wptr <= r_wptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntW'(1);
                2'b01:   r_count <= r_count - CntW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Source FIFO storage, written at the write pointer on every burst start.
    // NOTE: the storage array has no reset; r_count alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_fifo[r_wptr] <= w_push_src;
        end
    end

    // Ready goes back only to the requester currently driving the output.
    always_comb begin
        req_ready_o = '0;
        if (w_active) begin
            req_ready_o[w_sel] = out_ready_i;
        end
    end

    // Completion pulse to the owner of the oldest outstanding burst.
    always_comb begin
        ack_o = '0;
        if (w_pop) begin
            ack_o[r_fifo[r_rptr]] = 1'b1;
        end
    end

    assign out_valid_o = w_out_valid;
    assign out_src_o   = w_sel;
    assign out_addr_o  = req_addr_i[w_sel*AddrWidth +: AddrWidth];
    assign out_data_o  = req_data_i[w_sel*DataWidth +: DataWidth];
    assign out_strb_o  = req_strb_i[w_sel*StrbW +: StrbW];
    assign out_last_o  = req_last_i[w_sel];
    assign ack_err_o   = r_ack_err;
    assign busy_o      = (r_state == ST_LOCKED) | (|req_valid_i) | ~w_fifo_empty;

endmodule
